// File: rtl/ks_addsub_pipe.sv
// 16-bit add/subtract on a radix-2 Kogge-Stone prefix network, three register stages.
// Latency: 3 clk edges from acceptance to out_valid; one beat per clock when unstalled.
// Backpressure: whole pipe advances only when the output slot is empty or consumed; in_ready = advance.
module ks_addsub_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_sub,
  input  logic        in_cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_cout,
  output logic        out_ovf
);

  typedef struct packed {
    logic [15:0] p;
    logic [15:0] g;
    logic        c0;
    logic        a_s;
    logic        b_s;
  } s1_t;

  typedef struct packed {
    logic [15:0] p_bit;
    logic [15:0] pg;
    logic [15:0] gg;
    logic        c0;
    logic        a_s;
    logic        b_s;
  } s2_t;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } s3_t;

  // One prefix level: node i combines with node i-span. Nodes below span pass through;
  // nodes in [span, 2*span) act as gray cells (their group P is never consumed later).
  function automatic logic [15:0] ks_g(input logic [15:0] g, input logic [15:0] p, input int span);
    return g | (p & (g << span));
  endfunction

  function automatic logic [15:0] ks_p(input logic [15:0] p, input int span);
    return p & ((p << span) | ~(16'hFFFF << span));
  endfunction

  logic v1, v2, v3;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  s3_t  s3_q, s3_d;
  logic advance;

  logic [15:0] b_eff;
  logic [15:0] l1_g, l1_p, l3_g, l3_p, l4_g;

  assign advance  = !v3 || out_ready;
  assign in_ready = advance;

  always_comb begin
    b_eff       = in_sub ? ~in_b : in_b;
    s1_d.c0     = in_sub | in_cin;
    s1_d.p      = in_a ^ b_eff;
    s1_d.g      = in_a & b_eff;
    // carry-in folded into G[0] so G[i] becomes the carry out of bit i
    s1_d.g[0]   = s1_d.g[0] | (s1_d.p[0] & s1_d.c0);
    s1_d.a_s    = in_a[15];
    s1_d.b_s    = b_eff[15];
  end

  always_comb begin
    l1_g       = ks_g(s1_q.g, s1_q.p, 1);
    l1_p       = ks_p(s1_q.p, 1);
    s2_d.gg    = ks_g(l1_g, l1_p, 2);
    s2_d.pg    = ks_p(l1_p, 2);
    s2_d.p_bit = s1_q.p;
    s2_d.c0    = s1_q.c0;
    s2_d.a_s   = s1_q.a_s;
    s2_d.b_s   = s1_q.b_s;
  end

  always_comb begin
    l3_g      = ks_g(s2_q.gg, s2_q.pg, 4);
    l3_p      = ks_p(s2_q.pg, 4);
    l4_g      = ks_g(l3_g, l3_p, 8);
    s3_d.sum  = s2_q.p_bit ^ {l4_g[14:0], s2_q.c0};
    s3_d.cout = l4_g[15];
    s3_d.ovf  = (s2_q.a_s == s2_q.b_s) && (s3_d.sum[15] != s2_q.a_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (in_valid) s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign out_valid = v3;
  assign out_sum   = s3_q.sum;
  assign out_cout  = s3_q.cout;
  assign out_ovf   = s3_q.ovf;

endmodule

// File: tb/tb_ks_addsub_pipe.sv
// Directed and random checks of ks_addsub_pipe: arithmetic, latency, stalls, mid-flight reset.
module tb_ks_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  ks_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Sends one beat into an idle pipe with out_ready=1 and reports the result and edge count.
  task automatic run_single(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin,
                            output logic [15:0] sum, output logic cout, output logic ovf,
                            output int lat, output logic rdy_before);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_cin = cin; out_ready = 1'b1;
    #1 rdy_before = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!out_valid) lat = 99;
    sum = out_sum; cout = out_cout; ovf = out_ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if ({out_valid, in_ready, out_sum, out_cout, out_ovf} !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got valid=%b ready=%b sum=%h cout=%b ovf=%b, want 0 1 0000 0 0",
               out_valid, in_ready, out_sum, out_cout, out_ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_vectors(input string name, input vec_t v [6]);
    logic [15:0] sum;
    logic cout, ovf, rdy;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_single(v[i].a, v[i].b, v[i].sub, v[i].cin, sum, cout, ovf, lat, rdy);
      tests++;
      if ({sum, cout, ovf} !== {v[i].sum, v[i].cout, v[i].ovf}) begin
        fails++;
        $display("FAIL %s[%0d] %h,%h: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 name, i, v[i].a, v[i].b, sum, cout, ovf, v[i].sum, v[i].cout, v[i].ovf);
      end
      tests++;
      if (lat !== 3 || rdy !== 1'b1) begin
        fails++;
        $display("FAIL %s_latency[%0d]: got lat=%0d in_ready=%b want lat=3 in_ready=1", name, i, lat, rdy);
      end
    end
  endtask

  task automatic test_add;
    vec_t v [6];
    v = '{'{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0},
          '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
          '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
          '{16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b0},
          '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
          '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0}};
    test_vectors("add", v);
  endtask

  task automatic test_sub;
    vec_t v [6];
    v = '{'{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0},
          '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1},
          '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0},
          '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0},
          '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0},
          '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1}};
    test_vectors("sub", v);
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_sum [8];
    logic [15:0] prev_sum;
    logic prev_stall;
    int sent, got;
    exp_sum = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006, 16'h1007, 16'h1008};
    sent = 0; got = 0; prev_stall = 1'b0; prev_sum = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c < 8);
      if (sent < 8) begin
        in_valid = 1'b1; in_a = 16'(sent + 1); in_b = 16'h1000; in_sub = 1'b0; in_cin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL b2b_stall_ready c=%0d: got %b want 0", c, in_ready);
        end
        if (prev_stall) begin
          tests++;
          if (out_sum !== prev_sum) begin
            fails++;
            $display("FAIL b2b_hold c=%0d: got %h want %h", c, out_sum, prev_sum);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum = out_sum;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        tests++;
        if (got >= 8 || out_sum !== exp_sum[got & 7]) begin
          fails++;
          $display("FAIL b2b_order[%0d]: got %h want %h", got, out_sum, exp_sum[got & 7]);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (got !== 8 || sent !== 8) begin
      fails++;
      $display("FAIL b2b_count: got %0d results from %0d beats, want 8 from 8", got, sent);
    end
  endtask

  task automatic test_reset_midflight;
    int seen, first_lat;
    logic [15:0] first_sum;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 16'h0AA0 + 16'(i); in_b = 16'h0001; in_sub = 1'b0; in_cin = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midflight_full: got valid=%b ready=%b want 1 0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, in_ready, out_sum} !== {1'b0, 1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL midflight_async_clear: got valid=%b ready=%b sum=%h want 0 1 0000",
               out_valid, in_ready, out_sum);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'h0100; in_b = 16'h0200; in_sub = 1'b0; in_cin = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midflight_ready_after_release: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 0; first_lat = 0; first_sum = '0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (out_valid) begin
        if (seen == 0) begin
          first_lat = k;
          first_sum = out_sum;
        end
        seen++;
      end
    end
    tests++;
    if (seen !== 1 || first_lat !== 3 || first_sum !== 16'h0300) begin
      fails++;
      $display("FAIL midflight_no_stale: got %0d results, first at edge %0d sum=%h; want 1 at edge 3 sum=0300",
               seen, first_lat, first_sum);
    end
  endtask

  task automatic test_random;
    logic [17:0] q [$];
    logic [17:0] exp_r;
    logic [16:0] r17;
    logic [15:0] be;
    logic c0;
    int sent, got, cycles, rdy_err, bad;
    sent = 0; got = 0; cycles = 0; rdy_err = 0; bad = 0;
    while (got < 10000 && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      if (sent < 10000) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = 16'($urandom); in_b = 16'($urandom);
        in_sub = 1'($urandom); in_cin = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready !== (!out_valid || out_ready)) rdy_err++;
      if (in_valid && in_ready) begin
        be  = in_sub ? ~in_b : in_b;
        c0  = in_sub ? 1'b1 : in_cin;
        r17 = {1'b0, in_a} + {1'b0, be} + {16'h0000, c0};
        q.push_back({r17, (in_a[15] == be[15]) && (r17[15] != in_a[15])});
        sent++;
      end
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL random_extra[%0d]: got sum=%h with nothing outstanding", got, out_sum);
        end else begin
          exp_r = q.pop_front();
          if ({out_cout, out_sum, out_ovf} !== exp_r) begin
            fails++;
            bad++;
            if (bad < 10)
              $display("FAIL random[%0d]: got cout=%b sum=%h ovf=%b want cout=%b sum=%h ovf=%b",
                       got, out_cout, out_sum, out_ovf, exp_r[17], exp_r[16:1], exp_r[0]);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (got !== 10000 || q.size() !== 0) begin
      fails++;
      $display("FAIL random_count: got %0d results, %0d left outstanding, want 10000 and 0", got, q.size());
    end
    tests++;
    if (rdy_err !== 0) begin
      fails++;
      $display("FAIL random_in_ready: got %0d cycles with wrong in_ready, want 0", rdy_err);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ks_addsub_pipe.md
KS_ADDSUB_PIPE -- requirements
Module: ks_addsub_pipe

Interface
REQ-001 SHALL have no parameters; datapath width is fixed at 16 bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand beat offered.
REQ-005 SHALL have port: in_ready  output  1  operand beat accepted when in_valid and in_ready are both high at a clk edge.
REQ-006 SHALL have port: in_a  input  16  minuend / first addend.
REQ-007 SHALL have port: in_b  input  16  subtrahend / second addend.
REQ-008 SHALL have port: in_sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-009 SHALL have port: in_cin  input  1  carry-in, used only when in_sub=0.
REQ-010 SHALL have port: out_valid  output  1  result beat present.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts the result beat.
REQ-012 SHALL have port: out_sum  output  16  result bits [15:0].
REQ-013 SHALL have port: out_cout  output  1  carry-out of bit 15 (for sub: 1 = no borrow).
REQ-014 SHALL have port: out_ovf  output  1  signed two's-complement overflow.

Function
REQ-015 SHALL compute the result with a radix-2 Kogge-Stone prefix network: bitwise P/G, four prefix levels (span 1, 2, 4, 8) built from black and gray cells, then sum = P xor {G[14:0], c0}.
REQ-016 SHALL use c0 = in_sub ? 1 : in_cin and the effective B operand = in_sub ? ~in_b : in_b.
REQ-017 SHALL have a three-register pipeline: S1 captures bitwise P/G plus c0 folded into G[0]; S2 captures P/G after prefix levels 1-2; S3 captures the result after levels 3-4 and the sum XOR.
REQ-018 SHALL give a latency of exactly 3 clk edges from acceptance to out_valid high, with no stalls.
REQ-019 SHALL carry a valid bit per stage (v1, v2, v3); out_valid = v3.
REQ-020 SHALL define advance = !v3 || out_ready; all three stages shift only when advance=1, otherwise every stage holds its contents and valid bit.
REQ-021 SHALL drive in_ready = advance (combinational); in_ready must not depend on in_valid.
REQ-022 SHALL let bubbles flow: when advance=1 and no beat is accepted, v1 loads 0.
REQ-023 SHALL keep out_sum, out_cout and out_ovf stable while out_valid=1 and out_ready=0.
REQ-024 SHALL set out_cout = group generate G[15:0] (including c0).
REQ-025 SHALL set out_ovf = (A_eff[15] == B_eff[15]) && (sum[15] != A_eff[15]), where A_eff and B_eff are the operands actually added; the operand sign bits are piped alongside the data.
REQ-026 SHALL sustain one beat per clock when out_ready is held high.
REQ-027 SHALL, when a beat is accepted and a result is consumed on the same edge, perform both actions and keep the occupancy consistent.
REQ-028 SHALL produce results identical to a 17-bit behavioural add of A_eff + B_eff + c0 for all operand values, including wrap-around at 0xFFFF.

Reset
REQ-029 SHALL, while rst_n=0, clear v1, v2 and v3 to 0 asynchronously, so that out_valid=0 and in_ready=1.
REQ-030 SHALL reset out_sum to 0x0000, out_cout to 0 and out_ovf to 0; data registers may also be reset to 0.
REQ-031 SHALL discard all in-flight beats when reset is asserted mid-operation; no result for those beats appears after rst_n deasserts.
REQ-032 SHALL accept a new beat on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL cover this scenario: add 0x1234 + 0x4321, cin=0, out_ready=1 -> 3 cycles later sum=0x5555, cout=0, ovf=0.
REQ-034 SHALL cover this scenario: add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; add 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-035 SHALL cover this scenario: sub 0x0005 - 0x0007 -> sum=0xFFFE, cout=0; sub 0x8000 - 0x0001 -> sum=0x7FFF, ovf=1.
REQ-036 SHALL cover this scenario: back-to-back stream of 8 beats with out_ready=0 for 4 cycles mid-stream -> in_ready=0 while v3=1, no beat lost, duplicated or reordered, and outputs held during the stall.
REQ-037 SHALL cover this scenario: rst_n pulsed low with 3 beats in flight -> out_valid drops immediately, and no stale result appears after release.
REQ-038 SHALL cover this scenario: 10k random A/B/sub/cin beats with random in_valid/out_ready -> every result matches the reference model of REQ-028.
